// File: rtl/fpu_ss_pkg.sv
// Shared types and width helpers for the multi-core fpu_ss front end.
package fpu_ss_pkg;

  localparam int unsigned ARB_CORE_W = 4;   // holds a core index for up to 16 cores
  localparam int unsigned ARB_ID_W   = 32;  // widest supported core-side instruction id

  typedef struct packed {
    logic                  valid;
    logic [ARB_CORE_W-1:0] core;
    logic [ARB_ID_W-1:0]   orig_id;
    logic                  commit_pend;
    logic                  kill;
  } arb_entry_t;

  // Index width for n items; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/fpu_ss_core_arbiter_chk.sv
// Protocol checks on the fpu_ss side of the core arbiter.
module fpu_ss_core_arbiter_chk (
  input logic clk_i,
  input logic rst_ni,
  input logic result_valid_i,
  input logic result_tag_known_i
);

  // fpu_ss must only return results on tags that are in flight.
  a_result_tag_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
    result_valid_i |-> result_tag_known_i);

endmodule

// File: rtl/fpu_ss_rr_arbiter.sv
// Round-robin arbiter whose grant is held while a request is pending downstream.
module fpu_ss_rr_arbiter #(
  parameter int unsigned NB_REQ = 8,
  parameter int unsigned IDX_W  = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [NB_REQ-1:0] req_i,
  input  logic              lock_i,
  input  logic              advance_i,
  output logic [NB_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]  idx_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d, held_q, held_d, pick_s, cand_s;
  logic             locked_q, locked_d, found_s;

  // First requester at or after the pointer, wrapping around.
  always_comb begin
    pick_s  = ptr_q;
    found_s = 1'b0;
    cand_s  = ptr_q;
    for (int unsigned k = 0; k < NB_REQ; k++) begin
      cand_s = IDX_W'((32'(ptr_q) + k) % NB_REQ);
      if (!found_s && req_i[cand_s]) begin
        pick_s  = cand_s;
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant output, lock tracking and pointer advance.
  always_comb begin
    idx_o    = locked_q ? held_q : pick_s;
    gnt_o    = (|req_i) ? (NB_REQ'(1'b1) << idx_o) : '0;
    locked_d = lock_i & ~advance_i;
    held_d   = idx_o;
    if (advance_i) begin
      ptr_d = (idx_o == IDX_W'(NB_REQ - 1)) ? '0 : idx_o + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer and lock state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      held_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      ptr_q    <= ptr_d;
      held_q   <= held_d;
      locked_q <= locked_d;
    end
  end

endmodule

// File: rtl/fpu_ss_core_arbiter.sv
// Shares one fpu_ss among several cores: round-robin issue, id-to-tag remap,
// per-tag commit forwarding and result routing back to the owning core.
module fpu_ss_core_arbiter
  import fpu_ss_pkg::*;
#(
  parameter  int unsigned NB_CORES     = 8,
  parameter  int unsigned ID_WIDTH     = 4,
  parameter  int unsigned TAG_DEPTH    = 4,
  parameter  int unsigned RESULT_WIDTH = 32,
  localparam int unsigned TAG_W        = idx_width(TAG_DEPTH)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NB_CORES-1:0]          core_issue_valid_i,
  output logic [NB_CORES-1:0]          core_issue_ready_o,
  input  logic [NB_CORES*32-1:0]       core_issue_instr_i,
  input  logic [NB_CORES*ID_WIDTH-1:0] core_issue_id_i,
  output logic                         core_issue_accept_o,
  input  logic [NB_CORES-1:0]          core_commit_valid_i,
  input  logic [NB_CORES*ID_WIDTH-1:0] core_commit_id_i,
  input  logic [NB_CORES-1:0]          core_commit_kill_i,
  output logic [NB_CORES-1:0]          core_result_valid_o,
  input  logic [NB_CORES-1:0]          core_result_ready_i,
  output logic [ID_WIDTH-1:0]          core_result_id_o,
  output logic [RESULT_WIDTH-1:0]      core_result_data_o,
  output logic                         fpu_issue_valid_o,
  input  logic                         fpu_issue_ready_i,
  output logic [31:0]                  fpu_issue_instr_o,
  output logic [TAG_W-1:0]             fpu_issue_id_o,
  output logic [31:0]                  fpu_core_id_o,
  input  logic                         fpu_issue_accept_i,
  output logic                         fpu_commit_valid_o,
  output logic [TAG_W-1:0]             fpu_commit_id_o,
  output logic                         fpu_commit_kill_o,
  input  logic                         fpu_result_valid_i,
  output logic                         fpu_result_ready_o,
  input  logic [TAG_W-1:0]             fpu_result_id_i,
  input  logic [RESULT_WIDTH-1:0]      fpu_result_data_i,
  output logic [TAG_W:0]               inflight_cnt_o,
  output logic                         busy_o
);

  localparam int unsigned CORE_IDX_W = idx_width(NB_CORES);
  localparam int unsigned CNT_W      = TAG_W + 1;

  arb_entry_t              entry_q [TAG_DEPTH];
  arb_entry_t              entry_d [TAG_DEPTH];
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NB_CORES-1:0]     gnt_s;
  logic [CORE_IDX_W-1:0]   gnt_idx_s;
  logic [31:0]             issue_instr_s;
  logic [ID_WIDTH-1:0]     issue_id_s;
  logic                    gnt_cmt_hit_s, gnt_cmt_kill_s;
  logic [TAG_W-1:0]        alloc_tag_s, cmt_tag_s;
  logic                    any_free_s, cmt_valid_s, issue_hs_s, res_known_s, res_hs_s;
  logic [TAG_DEPTH-1:0]    cap_hit_s, cap_kill_s;

  fpu_ss_rr_arbiter #(.NB_REQ(NB_CORES), .IDX_W(CORE_IDX_W)) u_rr (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (core_issue_valid_i),
    .lock_i    (fpu_issue_valid_o),
    .advance_i (issue_hs_s),
    .gnt_o     (gnt_s),
    .idx_o     (gnt_idx_s)
  );

  // Steer the granted core's issue lane and any same-cycle commit of that id.
  always_comb begin
    issue_instr_s  = 32'd0;
    issue_id_s     = '0;
    gnt_cmt_hit_s  = 1'b0;
    gnt_cmt_kill_s = 1'b0;
    for (int c = 0; c < NB_CORES; c++) begin
      if (gnt_idx_s == CORE_IDX_W'(c)) begin
        issue_instr_s  = core_issue_instr_i[c*32 +: 32];
        issue_id_s     = core_issue_id_i[c*ID_WIDTH +: ID_WIDTH];
        gnt_cmt_hit_s  = core_commit_valid_i[c] &&
                         (core_commit_id_i[c*ID_WIDTH +: ID_WIDTH] == core_issue_id_i[c*ID_WIDTH +: ID_WIDTH]);
        gnt_cmt_kill_s = gnt_cmt_hit_s & core_commit_kill_i[c];
      end else begin
        issue_instr_s  = issue_instr_s;
      end
    end
  end

  // Lowest free tag for allocation, lowest pending commit for forwarding.
  always_comb begin
    alloc_tag_s = '0;
    any_free_s  = 1'b0;
    cmt_tag_s   = '0;
    cmt_valid_s = 1'b0;
    for (int t = 0; t < TAG_DEPTH; t++) begin
      if (!any_free_s && !entry_q[t].valid) begin
        alloc_tag_s = TAG_W'(t);
        any_free_s  = 1'b1;
      end else begin
        any_free_s  = any_free_s;
      end
      if (!cmt_valid_s && entry_q[t].commit_pend) begin
        cmt_tag_s   = TAG_W'(t);
        cmt_valid_s = 1'b1;
      end else begin
        cmt_valid_s = cmt_valid_s;
      end
    end
  end

  // CAM every core's commit against the in-flight entries it owns.
  always_comb begin
    cap_hit_s  = '0;
    cap_kill_s = '0;
    for (int t = 0; t < TAG_DEPTH; t++) begin
      for (int c = 0; c < NB_CORES; c++) begin
        if (core_commit_valid_i[c] && entry_q[t].valid && !entry_q[t].commit_pend &&
            (entry_q[t].core == ARB_CORE_W'(c)) &&
            (entry_q[t].orig_id == ARB_ID_W'(core_commit_id_i[c*ID_WIDTH +: ID_WIDTH]))) begin
          cap_hit_s[t]  = 1'b1;
          cap_kill_s[t] = core_commit_kill_i[c];
        end else begin
          cap_hit_s[t]  = cap_hit_s[t];
        end
      end
    end
  end

  // Issue, commit and result datapaths; everything is held quiet in reset.
  always_comb begin
    issue_hs_s          = fpu_issue_valid_o & fpu_issue_ready_i;
    fpu_issue_valid_o   = rst_ni & (|core_issue_valid_i) & any_free_s;
    core_issue_ready_o  = gnt_s & {NB_CORES{rst_ni & fpu_issue_ready_i & any_free_s}};
    core_issue_accept_o = fpu_issue_accept_i;
    fpu_issue_instr_o   = issue_instr_s;
    fpu_issue_id_o      = alloc_tag_s;
    fpu_core_id_o       = 32'(gnt_idx_s);
    fpu_commit_valid_o  = cmt_valid_s;
    fpu_commit_id_o     = cmt_tag_s;
    fpu_commit_kill_o   = cmt_valid_s & entry_q[cmt_tag_s].kill;
    res_known_s         = entry_q[fpu_result_id_i].valid;
    core_result_valid_o = (rst_ni & fpu_result_valid_i & res_known_s) ?
                          (NB_CORES'(1'b1) << entry_q[fpu_result_id_i].core) : '0;
    core_result_id_o    = entry_q[fpu_result_id_i].orig_id[ID_WIDTH-1:0];
    core_result_data_o  = fpu_result_data_i;
    // Unknown tags are swallowed so a stray result cannot wedge fpu_ss.
    fpu_result_ready_o  = rst_ni & (res_known_s ?
                          core_result_ready_i[entry_q[fpu_result_id_i].core[CORE_IDX_W-1:0]] : 1'b1);
    res_hs_s            = fpu_result_valid_i & fpu_result_ready_o & res_known_s;
    inflight_cnt_o      = cnt_q;
    busy_o              = |cnt_q;
  end

  // Per-tag next state: allocate, free, forward commit, capture commit.
  always_comb begin
    cnt_d = '0;
    for (int t = 0; t < TAG_DEPTH; t++) begin
      entry_d[t] = entry_q[t];
      if (issue_hs_s && fpu_issue_accept_i && (alloc_tag_s == TAG_W'(t))) begin
        entry_d[t].valid       = 1'b1;
        entry_d[t].core        = ARB_CORE_W'(gnt_idx_s);
        entry_d[t].orig_id     = ARB_ID_W'(issue_id_s);
        entry_d[t].commit_pend = gnt_cmt_hit_s;
        entry_d[t].kill        = gnt_cmt_kill_s;
      end else if ((res_hs_s && (fpu_result_id_i == TAG_W'(t))) ||
                   (cmt_valid_s && (cmt_tag_s == TAG_W'(t)) && entry_q[t].kill)) begin
        entry_d[t] = '0;
      end else if (cmt_valid_s && (cmt_tag_s == TAG_W'(t))) begin
        entry_d[t].commit_pend = 1'b0;
      end else if (cap_hit_s[t]) begin
        entry_d[t].commit_pend = 1'b1;
        entry_d[t].kill        = cap_kill_s[t];
      end else begin
        entry_d[t] = entry_q[t];
      end
      cnt_d = cnt_d + CNT_W'(entry_d[t].valid);
    end
  end

  // Tag table and occupancy count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int t = 0; t < TAG_DEPTH; t++) begin
        entry_q[t] <= '0;
      end
      cnt_q <= '0;
    end else begin
      entry_q <= entry_d;
      cnt_q   <= cnt_d;
    end
  end

  fpu_ss_core_arbiter_chk u_chk (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .result_valid_i     (fpu_result_valid_i),
    .result_tag_known_i (res_known_s)
  );

endmodule

// File: tb/tb_fpu_ss_core_arbiter.sv
// Directed bench for fpu_ss_core_arbiter with hand-computed expectations.
module tb_fpu_ss_core_arbiter;

  localparam int NB  = 8;
  localparam int IDW = 4;
  localparam int TW  = 2;
  localparam int RW  = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [NB-1:0]     civ, cir, ccv, cck, crv, crr;
  logic [NB*32-1:0]  cinstr;
  logic [NB*IDW-1:0] cid, ccid;
  logic              cacc, fiv, fir, facc, fcv, fck, frv, frr, busy;
  logic [IDW-1:0]    crid;
  logic [RW-1:0]     crdata, frdata;
  logic [31:0]       finstr, fcore;
  logic [TW-1:0]     fid, fcid, frid;
  logic [TW:0]       cnt;

  int n_pass = 0;
  int n_chk  = 0;
  int t1_core [3] = '{0, 3, 5};
  logic [7:0] t3_vec [4] = '{8'h10, 8'h10, 8'h40, 8'h10};
  logic [3:0] t3_id  [4] = '{4'd0, 4'd1, 4'd9, 4'd3};

  always #5 clk = ~clk;

  fpu_ss_core_arbiter dut (
    .clk_i (clk), .rst_ni (rst_n),
    .core_issue_valid_i (civ), .core_issue_ready_o (cir), .core_issue_instr_i (cinstr),
    .core_issue_id_i (cid), .core_issue_accept_o (cacc),
    .core_commit_valid_i (ccv), .core_commit_id_i (ccid), .core_commit_kill_i (cck),
    .core_result_valid_o (crv), .core_result_ready_i (crr), .core_result_id_o (crid),
    .core_result_data_o (crdata),
    .fpu_issue_valid_o (fiv), .fpu_issue_ready_i (fir), .fpu_issue_instr_o (finstr),
    .fpu_issue_id_o (fid), .fpu_core_id_o (fcore), .fpu_issue_accept_i (facc),
    .fpu_commit_valid_o (fcv), .fpu_commit_id_o (fcid), .fpu_commit_kill_o (fck),
    .fpu_result_valid_i (frv), .fpu_result_ready_o (frr), .fpu_result_id_i (frid),
    .fpu_result_data_i (frdata),
    .inflight_cnt_o (cnt), .busy_o (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input int c, input logic [IDW-1:0] id);
    civ[c] = 1'b1;
    cinstr[c*32 +: 32] = 32'hA000_0000 | 32'(c);
    cid[c*IDW +: IDW] = id;
  endtask

  initial begin
    rst_n = 1'b0; civ = '0; cinstr = '0; cid = '0; ccv = '0; ccid = '0; cck = '0;
    crr = '0; fir = 1'b0; facc = 1'b0; frv = 1'b0; frid = '0; frdata = '0;
    #2;
    check("rst_issue_valid", fiv, 0);
    check("rst_issue_ready", cir, 0);
    check("rst_commit_valid", fcv, 0);
    check("rst_inflight", cnt, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Three simultaneous requesters served in round-robin order.
    fir = 1'b1; facc = 1'b1; crr = '1;
    set_issue(0, 4'd0); set_issue(3, 4'd3); set_issue(5, 4'd5);
    #1;
    check("t1_valid", fiv, 1);
    check("t1_core_a", fcore, 0);
    check("t1_tag_a", fid, 0);
    check("t1_ready_a", cir, 8'h01);
    check("t1_instr_a", finstr, 32'hA000_0000);
    step(); civ[0] = 1'b0; #1;
    check("t1_core_b", fcore, 3);
    check("t1_tag_b", fid, 1);
    check("t1_ready_b", cir, 8'h08);
    step(); civ[3] = 1'b0; #1;
    check("t1_core_c", fcore, 5);
    check("t1_tag_c", fid, 2);
    step(); civ[5] = 1'b0; #1;
    check("t1_inflight", cnt, 3);
    check("t1_busy", busy, 1);
    check("t1_idle", fiv, 0);
    frv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      frid = TW'(i); frdata = 32'hD000_0000 + 32'(i); #1;
      check("t1_res_valid", crv, 8'h01 << t1_core[i]);
      check("t1_res_id", crid, t1_core[i]);
      check("t1_res_data", crdata, 32'hD000_0000 + 32'(i));
      step();
    end
    frv = 1'b0; #1;
    check("t1_drained", cnt, 0);

    // Same id from two cores; results return out of order.
    set_issue(1, 4'd4); set_issue(2, 4'd4); #1;
    check("t2_core_a", fcore, 1);
    check("t2_tag_a", fid, 0);
    step(); civ[1] = 1'b0; #1;
    check("t2_core_b", fcore, 2);
    check("t2_tag_b", fid, 1);
    step(); civ[2] = 1'b0;
    frv = 1'b1; frid = 2'd1; crr = 8'hFB; #1;
    check("t2_res1_valid", crv, 8'h04);
    check("t2_res1_id", crid, 4);
    check("t2_res1_stall", frr, 0);
    step(); crr = '1; #1;
    check("t2_res1_ready", frr, 1);
    step(); frid = 2'd0; #1;
    check("t2_res0_valid", crv, 8'h02);
    check("t2_res0_id", crid, 4);
    step(); frv = 1'b0;

    // Fill every tag, then a new requester waits for a freed tag.
    for (int i = 0; i < 4; i++) begin
      set_issue(4, IDW'(i)); #1;
      check("t3_fill_tag", fid, i);
      check("t3_fill_core", fcore, 4);
      step();
    end
    civ[4] = 1'b0; set_issue(6, 4'd9); #1;
    check("t3_full_cnt", cnt, 4);
    check("t3_full_ready", cir, 0);
    check("t3_full_valid", fiv, 0);
    step();
    check("t3_still_full", cir, 0);
    frv = 1'b1; frid = 2'd2; #1;
    check("t3_free_valid", crv, 8'h10);
    check("t3_free_id", crid, 2);
    check("t3_free_same_cycle", cir, 0);
    step(); frv = 1'b0; #1;
    check("t3_ready6", cir, 8'h40);
    check("t3_tag6", fid, 2);
    check("t3_core6", fcore, 6);
    step(); civ[6] = 1'b0; #1;
    check("t3_refull", cnt, 4);
    frv = 1'b1;
    for (int i = 0; i < 4; i++) begin
      frid = TW'(i); #1;
      check("t3_drain_valid", crv, t3_vec[i]);
      check("t3_drain_id", crid, t3_id[i]);
      step();
    end
    frv = 1'b0; #1;
    check("t3_drained", cnt, 0);

    // Grant is held while fpu_ss is not ready.
    fir = 1'b0; set_issue(0, 4'd1); #1;
    check("t4_valid", fiv, 1);
    check("t4_core", fcore, 0);
    check("t4_no_ready", cir, 0);
    step(); set_issue(7, 4'd2);
    for (int i = 0; i < 4; i++) begin
      #1;
      check("t4_locked", fcore, 0);
      step();
    end
    fir = 1'b1; #1;
    check("t4_hs_core", fcore, 0);
    check("t4_hs_ready", cir, 8'h01);
    step(); civ[0] = 1'b0; #1;
    check("t4_next_core", fcore, 7);
    check("t4_next_tag", fid, 1);
    step(); civ[7] = 1'b0;

    // Two commits in one cycle, one with kill.
    set_issue(4, 4'd5); #1;
    check("t5_core", fcore, 4);
    check("t5_tag", fid, 2);
    step(); civ[4] = 1'b0;
    ccv = 8'h11; ccid[0 +: 4] = 4'd1; ccid[16 +: 4] = 4'd5; cck = 8'h10; #1;
    check("t5_cmt_latency", fcv, 0);
    step(); ccv = '0; cck = '0; #1;
    check("t5_cmt_a_valid", fcv, 1);
    check("t5_cmt_a_id", fcid, 0);
    check("t5_cmt_a_kill", fck, 0);
    step();
    check("t5_cmt_b_valid", fcv, 1);
    check("t5_cmt_b_id", fcid, 2);
    check("t5_cmt_b_kill", fck, 1);
    check("t5_cnt_before", cnt, 3);
    step();
    check("t5_cmt_done", fcv, 0);
    check("t5_cnt_after", cnt, 2);
    frv = 1'b1; frid = 2'd0; #1;
    check("t5_res0_valid", crv, 8'h01);
    check("t5_res0_id", crid, 1);
    step(); frid = 2'd1; #1;
    check("t5_res1_valid", crv, 8'h80);
    check("t5_res1_id", crid, 2);
    step(); frv = 1'b0; #1;
    check("t5_drained", cnt, 0);

    // Rejected issue, same-cycle commit capture, then mid-stream reset.
    facc = 1'b0; set_issue(2, 4'd7); #1;
    check("t6_accept", cacc, 0);
    check("t6_core", fcore, 2);
    step(); civ[2] = 1'b0; facc = 1'b1; #1;
    check("t6_no_alloc", cnt, 0);
    ccv = 8'h04; ccid[8 +: 4] = 4'd7;
    step(); ccv = '0; #1;
    check("t6_no_commit", fcv, 0);
    set_issue(3, 4'd6); ccv = 8'h08; ccid[12 +: 4] = 4'd6; #1;
    check("t6_same_core", fcore, 3);
    check("t6_same_tag", fid, 0);
    step(); civ[3] = 1'b0; ccv = '0; #1;
    check("t6_same_cmt_valid", fcv, 1);
    check("t6_same_cmt_id", fcid, 0);
    check("t6_same_cmt_kill", fck, 0);
    check("t6_same_cnt", cnt, 1);
    set_issue(1, 4'd3); frv = 1'b1; frid = 2'd0; rst_n = 1'b0; #1;
    check("t6_rst_issue_valid", fiv, 0);
    check("t6_rst_issue_ready", cir, 0);
    check("t6_rst_cnt", cnt, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_commit", fcv, 0);
    check("t6_rst_res_ready", frr, 0);
    check("t6_rst_res_valid", crv, 0);
    frv = 1'b0;
    step(); rst_n = 1'b1; #1;
    check("t6_post_valid", fiv, 1);
    check("t6_post_core", fcore, 1);
    check("t6_post_tag", fid, 0);
    step(); civ = '0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fpu_ss_core_arbiter.md
Name: fpu_ss_core_arbiter

Overview:
- Multi-core front end for one shared fpu_ss in a cluster.
- Arbitrates NB_CORES X-interface issue channels round-robin onto the single fpu_ss issue port.
- Remaps each core's instruction id to a local tag, which removes id collisions between cores. Commits are forwarded per tag, and each result is routed back to its originating core with the original id.
- Sits between the cores' X-interfaces and fpu_ss, in place of the single-core wrapper.

Parameters:
- NB_CORES, 8, number of requesting cores (2..16).
- ID_WIDTH, 4, core-side X-interface instruction id width.
- TAG_DEPTH, 4, in-flight entries in the shared FPU (power of 2). TAG_W = $clog2(TAG_DEPTH).
- RESULT_WIDTH, 32, result data width.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- core_issue_valid_i  in  NB_CORES  per-core issue request
- core_issue_ready_o  out  NB_CORES  per-core issue handshake
- core_issue_instr_i  in  NB_CORES*32  per-core instruction
- core_issue_id_i  in  NB_CORES*ID_WIDTH  per-core instruction id
- core_issue_accept_o  out  1  accept flag from FPU; meaningful only for the granted core
- core_commit_valid_i  in  NB_CORES  per-core commit strobe
- core_commit_id_i  in  NB_CORES*ID_WIDTH  committed id
- core_commit_kill_i  in  NB_CORES  kill flag
- core_result_valid_o  out  NB_CORES  result valid toward owning core
- core_result_ready_i  in  NB_CORES  per-core result ready
- core_result_id_o  out  ID_WIDTH  original id of the current result
- core_result_data_o  out  RESULT_WIDTH  result data
- fpu_issue_valid_o  out  1  issue toward fpu_ss
- fpu_issue_ready_i  in  1
- fpu_issue_instr_o  out  32
- fpu_issue_id_o  out  TAG_W  allocated tag
- fpu_core_id_o  out  32  granted core index, zero-extended
- fpu_issue_accept_i  in  1
- fpu_commit_valid_o  out  1
- fpu_commit_id_o  out  TAG_W
- fpu_commit_kill_o  out  1
- fpu_result_valid_i  in  1
- fpu_result_ready_o  out  1
- fpu_result_id_i  in  TAG_W
- fpu_result_data_i  in  RESULT_WIDTH
- inflight_cnt_o  out  TAG_W+1  occupied entries
- busy_o  out  1  inflight_cnt_o != 0

Behaviour:
Reset
- All entries invalid; RR pointer = 0.
- All valid/ready outputs 0; inflight_cnt_o = 0.
- Reset mid-operation discards every entry with no flush traffic.

Entry state
- {valid, core, orig_id, commit_pend, kill}, one entry per tag.
- free_vec = ~valid, registered state.

Issue
- fpu_issue_valid_o = |core_issue_valid_i && |free_vec.
- Tag = lowest free index.
- Grant is round-robin starting at the pointer. Once fpu_issue_valid_o rises, the grant is locked until handshake; no retraction or switching while ready is low.
- core_issue_ready_o[g] = fpu_issue_ready_i && |free_vec; all other cores see 0.
- On handshake:
  - Pointer becomes g+1 mod NB_CORES.
  - If fpu_issue_accept_i = 1, entry[tag] is written valid with core = g, orig_id = id.
  - If accept = 0, no allocation is made.
- When full (no free tag), nothing is issued. Combinational latency core to FPU is 0.

Commit capture
- Each cycle, every core c with commit valid is CAM-matched against valid entries with core == c, orig_id == id and commit_pend == 0.
- A match sets commit_pend = 1 and kill = kill_i.
- A commit that matches the entry being allocated in the same cycle is written into the new entry.
- A commit with no match (rejected instruction) is dropped.
- All cores' commits are captured in the same cycle.

Commit issue
- fpu_commit_valid_o is driven from the lowest-index entry with commit_pend = 1. That entry's commit_pend clears the next cycle. No ready; minimum latency is 1 cycle.
- For kill = 1, the entry is freed in the same edge; fpu_ss produces no result for killed tags.

Results
- e = entry[fpu_result_id_i].
- core_result_valid_o[e.core] = fpu_result_valid_i. core_result_id_o = e.orig_id; data passes through. Path is combinational.
- fpu_result_ready_o = core_result_ready_i[e.core].
- Handshake frees the tag.
- A result on an invalid tag is an assertion error; ready is forced to 1 and the result is dropped.

Simultaneous events
- A tag freed in cycle N is allocatable in cycle N+1 (free_vec is registered).
- Free and allocate in the same cycle on different tags is legal.
- inflight_cnt_o = popcount(valid), registered.

Decomposition:
- fpu_ss_pkg gains `arb_entry_t` (struct above), `TAG_W` derivation helper, and `CORE_IDX_W = $clog2(NB_CORES)`.
- One sub-module: fpu_ss_rr_arbiter (NB_CORES request vector, lock input, grant one-hot + index, pointer register).

Test Plan:
- Cores 0,3,5 issue together, FPU always ready/accept → grants 0,3,5 in order; tags 0,1,2; fpu_core_id_o = 0,3,5.
- Cores 1 and 2 both send id 4 → tags 0/1; results return on tags 1 then 0 → core 2 receives id 4 first, then core 1 receives id 4.
- Fill all 4 tags, core 6 requests → core_issue_ready_o[6] = 0 until one result handshakes; issue on the following cycle.
- Hold fpu_issue_ready_i low 5 cycles while core 7 joins → grant stays on core 0; after handshake the next grant is core 7.
- Cores 0 and 4 commit the same cycle, core 4 with kill → fpu_commit on tag(core 0) then tag(core 4) with kill = 1; inflight_cnt_o drops by 1.
- Accept = 0 on issue, followed by a commit of that id → no entry allocated, no fpu_commit; mid-stream rst_ni low → all outputs 0, inflight_cnt_o = 0.
